// File: rtl/ring_pkg.sv
// Shared definitions for the ring router: packet layout, port ids and VC/buffer-state names.
package ring_pkg;

  localparam int PACKET_WIDTH = 64;

  // Packet fields are numbered MSB-first: bit 0 is the most significant bit.
  localparam int VC_BIT  = 0;
  localparam int DIR_BIT = 1;
  localparam int HOP_MSB = 8;
  localparam int HOP_LSB = 15;

  typedef enum logic [1:0] {
    CW  = 2'd0,
    CCW = 2'd1,
    PE  = 2'd2
  } port_e;

  localparam logic EVEN  = 1'b0;
  localparam logic ODD   = 1'b1;
  localparam logic FULL  = 1'b1;
  localparam logic EMPTY = 1'b0;

  typedef logic [0:PACKET_WIDTH-1] packet_t;

  // Only called for forwarded packets, whose hop count is known to be non-zero.
  function automatic packet_t dec_hop(input packet_t pkt);
    packet_t res;
    res = pkt;
    res[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - 8'd1;
    return res;
  endfunction

endpackage

// File: rtl/ring_router_rr_arb2.sv
// Two-request round-robin arbiter; the pointer moves past whichever request was granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic ptr_r;

  // Grant selection: single requests pass straight through, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) begin
        gnt = ptr_r ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end else begin
      gnt = 2'b00;
    end
  end

  // Pointer update: after a grant, the other requester gets priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 1'b0;
    end else if (gnt[0]) begin
      ptr_r <= 1'b1;
    end else if (gnt[1]) begin
      ptr_r <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_router.sv
// Bidirectional ring router with two polarity-alternated VCs per port.
// Optional stall counter port stall_cnt is built when RING_ROUTER_STATS_EN is defined.
module ring_router
  import ring_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  output logic                    polarity,
  input  logic                    cwsi,
  input  logic                    ccwsi,
  input  logic                    pesi,
  output logic                    cwri,
  output logic                    ccwri,
  output logic                    peri,
  input  logic [0:PACKET_WIDTH-1] cwdi,
  input  logic [0:PACKET_WIDTH-1] ccwdi,
  input  logic [0:PACKET_WIDTH-1] pedi,
  output logic                    cwso,
  output logic                    ccwso,
  output logic                    peso,
  input  logic                    cwro,
  input  logic                    ccwro,
  input  logic                    pero,
  output logic [0:PACKET_WIDTH-1] cwdo,
  output logic [0:PACKET_WIDTH-1] ccwdo,
  output logic [0:PACKET_WIDTH-1] pedo
`ifdef RING_ROUTER_STATS_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  logic    polarity_r;
  logic    in_full_r   [3][2];
  packet_t in_data_r   [3][2];
  logic    out_full_r  [3][2];
  packet_t out_data_r  [3][2];

  logic    q_s;
  logic    si_s        [3];
  logic    ro_s        [3];
  packet_t di_s        [3];
  logic    cap_s       [3];
  logic    drain_s     [3];
  packet_t cw_pkt_s;
  packet_t ccw_pkt_s;
  packet_t pe_pkt_s;
  logic    cw_eject_s;
  logic    ccw_eject_s;
  logic [1:0] req_s    [3];
  logic [1:0] gnt_s    [3];
  logic [1:0] gnt_vc_s [3][2];
  logic    in_clr_s    [3];
  logic    out_set_s   [3];
  packet_t out_wdata_s [3];

  assign q_s  = ~polarity_r;
  assign si_s = '{cwsi, ccwsi, pesi};
  assign ro_s = '{cwro, ccwro, pero};
  assign di_s = '{cwdi, ccwdi, pedi};

  // Link phase on VC polarity: accept into empty input buffers, release full outputs.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      cap_s[p]   = si_s[p] & ~in_full_r[p][polarity_r];
      drain_s[p] = out_full_r[p][polarity_r] & ro_s[p];
    end
  end

  assign polarity = polarity_r;
  assign cwri  = ~in_full_r[CW][polarity_r];
  assign ccwri = ~in_full_r[CCW][polarity_r];
  assign peri  = ~in_full_r[PE][polarity_r];
  assign cwso  = drain_s[CW];
  assign ccwso = drain_s[CCW];
  assign peso  = drain_s[PE];
  assign cwdo  = out_data_r[CW][polarity_r];
  assign ccwdo = out_data_r[CCW][polarity_r];
  assign pedo  = out_data_r[PE][polarity_r];

  assign cw_pkt_s    = in_data_r[CW][q_s];
  assign ccw_pkt_s   = in_data_r[CCW][q_s];
  assign pe_pkt_s    = in_data_r[PE][q_s];
  assign cw_eject_s  = (cw_pkt_s[HOP_MSB:HOP_LSB] == 8'd0);
  assign ccw_eject_s = (ccw_pkt_s[HOP_MSB:HOP_LSB] == 8'd0);

  // Crossbar requests on VC ~polarity; bit 0 is the ring input, bit 1 the other contender.
  always_comb begin
    req_s[CW]  = {in_full_r[PE][q_s]  & ~pe_pkt_s[DIR_BIT], in_full_r[CW][q_s]  & ~cw_eject_s};
    req_s[CCW] = {in_full_r[PE][q_s]  &  pe_pkt_s[DIR_BIT], in_full_r[CCW][q_s] & ~ccw_eject_s};
    req_s[PE]  = {in_full_r[CCW][q_s] &  ccw_eject_s,       in_full_r[CW][q_s]  &  cw_eject_s};
  end

  for (genvar o = 0; o < 3; o++) begin : g_out
    for (genvar v = 0; v < 2; v++) begin : g_vc
      logic [1:0] vc_req_s;
      assign vc_req_s = (q_s == 1'(v)) ? req_s[o] : 2'b00;
      rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (vc_req_s),
        .grant_en (~out_full_r[o][v]),
        .gnt      (gnt_vc_s[o][v])
      );
    end
    assign gnt_s[o] = gnt_vc_s[o][q_s];
  end

  // Crossbar moves: winners leave their input buffer, ring-to-ring traffic loses one hop.
  always_comb begin
    in_clr_s[CW]     = gnt_s[CW][0]  | gnt_s[PE][0];
    in_clr_s[CCW]    = gnt_s[CCW][0] | gnt_s[PE][1];
    in_clr_s[PE]     = gnt_s[CW][1]  | gnt_s[CCW][1];
    for (int o = 0; o < 3; o++) begin
      out_set_s[o] = |gnt_s[o];
    end
    out_wdata_s[CW]  = gnt_s[CW][1]  ? pe_pkt_s  : dec_hop(cw_pkt_s);
    out_wdata_s[CCW] = gnt_s[CCW][1] ? pe_pkt_s  : dec_hop(ccw_pkt_s);
    out_wdata_s[PE]  = gnt_s[PE][1]  ? ccw_pkt_s : cw_pkt_s;
  end

  // Buffer and polarity state; link and crossbar always touch different VCs.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_r <= EVEN;
      for (int p = 0; p < 3; p++) begin
        for (int v = 0; v < 2; v++) begin
          in_full_r[p][v]  <= EMPTY;
          in_data_r[p][v]  <= '0;
          out_full_r[p][v] <= EMPTY;
          out_data_r[p][v] <= '0;
        end
      end
    end else begin
      polarity_r <= ~polarity_r;
      for (int p = 0; p < 3; p++) begin
        if (cap_s[p]) begin
          in_full_r[p][polarity_r] <= FULL;
          in_data_r[p][polarity_r] <= di_s[p];
        end
        if (in_clr_s[p]) begin
          in_full_r[p][q_s] <= EMPTY;
        end
        if (drain_s[p]) begin
          out_full_r[p][polarity_r] <= EMPTY;
        end
        if (out_set_s[p]) begin
          out_full_r[p][q_s] <= FULL;
          out_data_r[p][q_s] <= out_wdata_s[p];
        end
      end
    end
  end

`ifdef RING_ROUTER_STATS_EN
  logic        stall_s;
  logic [15:0] stall_cnt_r;

  assign stall_s = |((req_s[CW] & ~gnt_s[CW]) | (req_s[CCW] & ~gnt_s[CCW]) | (req_s[PE] & ~gnt_s[PE]));

  // Saturating count of cycles with at least one unserved crossbar request.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ring_router.sv
// Self-checking bench for ring_router: directed scenarios plus random traffic against a packet-level model.
module tb_ring_router;

  localparam int P_CW  = 0;
  localparam int P_CCW = 1;
  localparam int P_PE  = 2;
  localparam logic [63:0] HOP_ONE = 64'h0001_0000_0000_0000;

  logic        clk, reset;
  logic        polarity;
  logic        cwsi, ccwsi, pesi, cwri, ccwri, peri;
  logic [63:0] cwdi, ccwdi, pedi, cwdo, ccwdo, pedo;
  logic        cwso, ccwso, peso, cwro, ccwro, pero;
`ifdef RING_ROUTER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: packets held per port / VC, plus the favoured input of each output per VC.
  bit          mi_v [3][2];
  logic [63:0] mi_d [3][2];
  bit          mo_v [3][2];
  logic [63:0] mo_d [3][2];
  int          fav  [3][2];
  bit          m_pol;
  int          m_stall;
  int          cand_a [3] = '{P_CW, P_CCW, P_CW};
  int          cand_b [3] = '{P_PE, P_PE,  P_CCW};
  string       pname  [3] = '{"cw", "ccw", "pe"};

  ring_router dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
    .cwri(cwri), .ccwri(ccwri), .peri(peri),
    .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
    .cwso(cwso), .ccwso(ccwso), .peso(peso),
    .cwro(cwro), .ccwro(ccwro), .pero(pero),
    .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
`ifdef RING_ROUTER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Destination port of a packet sitting at input x: PE input by direction, ring inputs by hop count.
  function automatic int dest(input int x, input logic [63:0] pkt);
    if (x == P_PE) return pkt[62] ? P_CCW : P_CW;
    return (pkt[55:48] == 8'd0) ? P_PE : x;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 3; p++)
      for (int v = 0; v < 2; v++) begin
        mi_v[p][v] = 0; mi_d[p][v] = '0; mo_v[p][v] = 0; mo_d[p][v] = '0;
        fav[p][v] = cand_a[p];
      end
    m_pol = 0;
    m_stall = 0;
  endtask

  task automatic m_step();
    bit sv[3], rv[3];
    logic [63:0] dv[3];
    int p, q, n, w;
    int cands[2];
    bit starve;
    logic [63:0] pkt;
    if (reset) begin m_reset(); return; end
    sv = '{cwsi, ccwsi, pesi};
    rv = '{cwro, ccwro, pero};
    dv = '{cwdi, ccwdi, pedi};
    p = int'(m_pol);
    q = 1 - p;
    for (int x = 0; x < 3; x++) begin
      if (sv[x] && !mi_v[x][p]) begin mi_v[x][p] = 1; mi_d[x][p] = dv[x]; end
      if (mo_v[x][p] && rv[x]) mo_v[x][p] = 0;
    end
    starve = 0;
    for (int o = 0; o < 3; o++) begin
      n = 0;
      for (int x = 0; x < 3; x++)
        if (mi_v[x][q] && dest(x, mi_d[x][q]) == o) begin cands[n] = x; n++; end
      if (n == 0) continue;
      if (mo_v[o][q]) begin starve = 1; continue; end
      if (n == 2) begin w = fav[o][q]; starve = 1; end
      else w = cands[0];
      pkt = mi_d[w][q];
      if (w != P_PE && o != P_PE) pkt = pkt - HOP_ONE;
      mo_v[o][q] = 1; mo_d[o][q] = pkt; mi_v[w][q] = 0;
      fav[o][q] = (w == cand_a[o]) ? cand_b[o] : cand_a[o];
    end
    if (starve && m_stall < 65535) m_stall++;
    m_pol = ~m_pol;
  endtask

  task automatic check_outputs();
    logic riv[3], sov[3], rv[3];
    logic [63:0] dov[3];
    int p;
    riv = '{cwri, ccwri, peri};
    sov = '{cwso, ccwso, peso};
    rv  = '{cwro, ccwro, pero};
    dov = '{cwdo, ccwdo, pedo};
    p = int'(m_pol);
    chk("polarity", 64'(polarity), 64'(m_pol));
    for (int x = 0; x < 3; x++) begin
      chk({pname[x], "_ri"}, 64'(riv[x]), 64'(!mi_v[x][p]));
      chk({pname[x], "_so"}, 64'(sov[x]), 64'(mo_v[x][p] && rv[x]));
      chk({pname[x], "_do"}, dov[x], mo_d[x][p]);
    end
`ifdef RING_ROUTER_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock: inputs were driven at the preceding negedge.
  task automatic cyc();
    #1;
    if (!reset) check_outputs();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cwsi = 0; ccwsi = 0; pesi = 0;
    cwdi = '0; ccwdi = '0; pedi = '0;
    cwro = 1; ccwro = 1; pero = 1;
  endtask

  initial begin
    logic [63:0] r;
    reset = 1;
    idle_inputs();
    m_reset();
    cyc();
    cyc();
    reset = 0;

    // A (P=0): PE injects vc0, dir ccw, hop 0
    pesi = 1; pedi = 64'h4000_0000_0000_0000;
    cyc();
    pesi = 0; pedi = '0;
    cyc();
    // C (P=0): leaves on the ccw link unchanged
    chk("inject_ccwso", 64'(ccwso), 64'd1);
    chk("inject_ccwdo", ccwdo, 64'h4000_0000_0000_0000);
    cyc();
    // D (P=1): cw packet with hop 0 is ejected to the NIC
    cwsi = 1; cwdi = 64'h8000_0000_0000_1234;
    cyc();
    cwsi = 0; cwdi = '0;
    cyc();
    chk("eject_peso", 64'(peso), 64'd1);
    chk("eject_pedo", pedo, 64'h8000_0000_0000_1234);
    // F (P=1): cw packet with hop 3 is forwarded with hop 2
    cwsi = 1; cwdi = 64'h0003_0000_0000_5678;
    cyc();
    cwsi = 0; cwdi = '0;
    cyc();
    chk("fwd_cwso", 64'(cwso), 64'd1);
    chk("fwd_cwdo", cwdo, 64'h0002_0000_0000_5678);
    cyc();
    // I (P=0): cw and ccw both eject on vc0 in the same cycle
    cwsi = 1; cwdi = 64'h0000_0000_0000_00C1;
    ccwsi = 1; ccwdi = 64'h4000_0000_0000_00C2;
    cyc();
    idle_inputs();
    cyc();
    chk("cont_first_peso", 64'(peso), 64'd1);
    chk("cont_first_pedo", pedo, 64'h0000_0000_0000_00C1);
    cyc();
    cyc();
    chk("cont_second_peso", 64'(peso), 64'd1);
    chk("cont_second_pedo", pedo, 64'h4000_0000_0000_00C2);

    // Backpressure: cw link blocked while cw traffic keeps arriving
    cwro = 0;
    for (int i = 0; i < 10; i++) begin
      cwsi = 1; cwdi = 64'h0005_0000_0000_0000 + 64'(i);
      chk("bp_cwso", 64'(cwso), 64'd0);
      cyc();
    end
    chk("bp_cwri", 64'(cwri), 64'd0);
    idle_inputs();
    for (int i = 0; i < 6; i++) cyc();

    // Random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 301) begin
        chk("midrst_polarity", 64'(polarity), 64'd0);
        chk("midrst_peri", 64'(peri), 64'd1);
        chk("midrst_ccwso", 64'(ccwso), 64'd0);
        chk("midrst_cwdo", cwdo, 64'd0);
      end
      cwsi  = 1'($urandom_range(0, 1));
      ccwsi = 1'($urandom_range(0, 1));
      pesi  = 1'($urandom_range(0, 1));
      cwro  = ($urandom_range(0, 3) != 0);
      ccwro = ($urandom_range(0, 3) != 0);
      pero  = ($urandom_range(0, 3) != 0);
      r = {$urandom, $urandom}; r[55:48] = 8'($urandom_range(0, 3)); cwdi = r;
      r = {$urandom, $urandom}; r[55:48] = 8'($urandom_range(0, 3)); ccwdi = r;
      r = {$urandom, $urandom}; r[55:48] = 8'($urandom_range(0, 3)); pedi = r;
      reset = (i == 300);
      cyc();
    end
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 20; i++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
